// File: rtl/fetch_stall_unit.sv
// fetch_stall_unit: fetch-side stall/redirect consumer for the 5-stage pipeline.
// Owns PC and the IF/ID register, applies PCWrite / IF_ID_Write / InstructionSel
// from the hazard detector, applies taken-branch redirects from ID, and keeps
// stall / protocol-error debug status.
// Ports:
//   Clock, Reset          - rising-edge clock, synchronous active-low reset
//   PCWrite, IF_ID_Write  - hazard-detector enables for PC and IF/ID
//   InstructionSel        - 0 inserts a bubble into ID/EX
//   Instruction_IF        - async instruction memory data at PC_IF
//   Branch_ID, BranchTarget_ID - taken redirect from ID and its target
//   PC_IF, Instruction_ID, PCPlus4_ID, Valid_ID - PC and IF/ID register outputs
//   Bubble_EX             - registered bubble flag to ID/EX
//   State                 - 00 RUN, 01 STALL, 10 REDIRECT
//   StallCount            - saturating stalled-cycle count
//   ProtocolErr           - sticky PCWrite != IF_ID_Write flag
module fetch_stall_unit #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned STALL_CNT_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       PCWrite,
    input  logic                       IF_ID_Write,
    input  logic                       InstructionSel,
    input  logic [DATA_WIDTH-1:0]      Instruction_IF,
    input  logic                       Branch_ID,
    input  logic [DATA_WIDTH-1:0]      BranchTarget_ID,
    output logic [DATA_WIDTH-1:0]      PC_IF,
    output logic [DATA_WIDTH-1:0]      Instruction_ID,
    output logic [DATA_WIDTH-1:0]      PCPlus4_ID,
    output logic                       Valid_ID,
    output logic                       Bubble_EX,
    output logic [1:0]                 State,
    output logic [STALL_CNT_WIDTH-1:0] StallCount,
    output logic                       ProtocolErr
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_STALL    = 2'b01,
        ST_REDIRECT = 2'b10
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    redirect;
    logic [DATA_WIDTH-1:0]   pc_plus4;
    logic [DATA_WIDTH-1:0]   target;

    // Redirect only from a real ID instruction, and never while IF/ID is stalled
    assign redirect = Branch_ID & Valid_ID & IF_ID_Write;
    assign pc_plus4 = PC_IF + DATA_WIDTH'(4);
    assign target   = BranchTarget_ID & ~DATA_WIDTH'(3);
    assign State    = state_q;

    // Next-state: redirect dominates, then stall, else run
    always_comb begin
        state_d = ST_RUN;
        if (redirect) begin
            state_d = ST_REDIRECT;
        end else if (!PCWrite) begin
            state_d = ST_STALL;
        end
    end

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, IF/ID and status registers
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            PC_IF          <= RESET_PC;
            Instruction_ID <= '0;
            PCPlus4_ID     <= '0;
            Valid_ID       <= 1'b0;
            Bubble_EX      <= 1'b1;
            StallCount     <= '0;
            ProtocolErr    <= 1'b0;
        end else begin
            if (redirect) begin
                PC_IF <= target;
            end else if (PCWrite) begin
                PC_IF <= pc_plus4;
            end

            // Flush the wrong-path fetch on redirect
            if (redirect) begin
                Instruction_ID <= '0;
                PCPlus4_ID     <= '0;
                Valid_ID       <= 1'b0;
            end else if (IF_ID_Write) begin
                Instruction_ID <= Instruction_IF;
                PCPlus4_ID     <= pc_plus4;
                Valid_ID       <= 1'b1;
            end

            Bubble_EX <= ~InstructionSel;

            if (!PCWrite && (StallCount != '1)) begin
                StallCount <= StallCount + STALL_CNT_WIDTH'(1);
            end

            if (PCWrite != IF_ID_Write) begin
                ProtocolErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stall_unit.sv
module tb_fetch_stall_unit;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          Clock;
    logic          Reset;
    logic          PCWrite;
    logic          IF_ID_Write;
    logic          InstructionSel;
    logic [DW-1:0] Instruction_IF;
    logic          Branch_ID;
    logic [DW-1:0] BranchTarget_ID;
    logic [DW-1:0] PC_IF;
    logic [DW-1:0] Instruction_ID;
    logic [DW-1:0] PCPlus4_ID;
    logic          Valid_ID;
    logic          Bubble_EX;
    logic [1:0]    State;
    logic [CW-1:0] StallCount;
    logic          ProtocolErr;

    fetch_stall_unit #(
        .DATA_WIDTH(DW),
        .STALL_CNT_WIDTH(CW),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .PCWrite(PCWrite),
        .IF_ID_Write(IF_ID_Write),
        .InstructionSel(InstructionSel),
        .Instruction_IF(Instruction_IF),
        .Branch_ID(Branch_ID),
        .BranchTarget_ID(BranchTarget_ID),
        .PC_IF(PC_IF),
        .Instruction_ID(Instruction_ID),
        .PCPlus4_ID(PCPlus4_ID),
        .Valid_ID(Valid_ID),
        .Bubble_EX(Bubble_EX),
        .State(State),
        .StallCount(StallCount),
        .ProtocolErr(ProtocolErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Asynchronous instruction memory: content derived from the address
    function automatic logic [DW-1:0] imem(input logic [DW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction
    assign Instruction_IF = imem(PC_IF);

    typedef struct {
        logic [DW-1:0] pc;
        logic [DW-1:0] instr;
        logic [DW-1:0] pc4;
        logic          valid;
        logic          bub;
        logic [1:0]    st;
        int            cnt;
        logic          err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [DW-1:0] m_pc, m_instr, m_pc4;
    logic          m_valid, m_bub, m_err;
    logic [1:0]    m_st;
    int            m_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    endtask

    // Drive one cycle of inputs, advance the model, and queue the expected outputs
    task automatic step(input logic rst, input logic pcw, input logic ifw,
                        input logic isel, input logic br, input logic [DW-1:0] tgt);
        logic taken;
        exp_t e;
        @(negedge Clock);
        Reset = rst; PCWrite = pcw; IF_ID_Write = ifw; InstructionSel = isel;
        Branch_ID = br; BranchTarget_ID = tgt;
        if (!rst) begin
            m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_bub = 1'b1;
            m_st = 2'd0; m_cnt = 0; m_err = 1'b0;
        end else begin
            taken = br && m_valid && ifw;
            if (taken) begin
                m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
            end else if (ifw) begin
                m_instr = imem(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            end
            if (taken)    m_pc = {tgt[DW-1:2], 2'b00};
            else if (pcw) m_pc = m_pc + 32'd4;
            m_bub = !isel;
            m_st  = taken ? 2'd2 : (!pcw ? 2'd1 : 2'd0);
            if (!pcw && m_cnt < CNT_MAX) m_cnt++;
            if (pcw != ifw) m_err = 1'b1;
        end
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
        e.bub = m_bub; e.st = m_st; e.cnt = m_cnt; e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: every edge with an outstanding expectation is compared
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("PC_IF", PC_IF, e.pc);
                chk("Instruction_ID", Instruction_ID, e.instr);
                chk("PCPlus4_ID", PCPlus4_ID, e.pc4);
                chk("Valid_ID", 32'(Valid_ID), 32'(e.valid));
                chk("Bubble_EX", 32'(Bubble_EX), 32'(e.bub));
                chk("State", 32'(State), 32'(e.st));
                chk("StallCount", 32'(StallCount), 32'(e.cnt));
                chk("ProtocolErr", 32'(ProtocolErr), 32'(e.err));
            end
        end
    end

    initial begin
        logic pcw, ifw, isel, br, rst;
        int r;
        Reset = 1'b0; PCWrite = 1'b0; IF_ID_Write = 1'b0; InstructionSel = 1'b0;
        Branch_ID = 1'b0; BranchTarget_ID = '0;

        // Reset with junk inputs, then free-run from RESET_PC
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
        run(4);
        // Two-cycle load-use stall at 0x10
        stall(2);
        run(1);
        // Redirect to 0x43 -> 0x40, then target instruction
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0043);
        run(2);
        // Branch during stall is deferred to the first unstalled cycle
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        run(2);
        // PC wrap from 0xFFFF_FFFC
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        run(3);
        // Reset mid-redirect, then counter saturation
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        run(2);
        stall(20);
        run(1);
        // Protocol error: PC advances, IF/ID holds, flag sticks until reset
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        run(3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        run(2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            r = $urandom_range(0, 15);
            if (r < 4)       begin pcw = 1'b0; ifw = 1'b0; end
            else if (r == 4) begin pcw = 1'b1; ifw = 1'b0; end
            else if (r == 5) begin pcw = 1'b0; ifw = 1'b1; end
            else             begin pcw = 1'b1; ifw = 1'b1; end
            isel = ($urandom_range(0, 7) == 0) ? ~pcw : pcw;
            br   = ($urandom_range(0, 5) == 0);
            step(rst, pcw, ifw, isel, br, 32'($urandom));
        end

        repeat (3) @(negedge Clock);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
